// File: rtl/dmem_lsu_hs.sv
// Data memory for the MEM stage with valid/ready request and response handshakes.
// Optional macro DMEM_PERF_CNT_EN adds saturating load/store/error counters.
module dmem_lsu_hs #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_errs
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               accept;
    logic               is_byte, is_half, is_word;
    logic               func3_ok, misaligned, out_of_range, req_err;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        load_data;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;
    logic               wr_en;

    // Address bits above the word index must all be zero, unless the index spans the whole address.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_oor
            assign out_of_range = |req_addr[ADDR_W-1:IDX_W+2];
        end else begin : g_no_oor
            assign out_of_range = 1'b0;
        end
    endgenerate

    always_comb begin
        accept     = req_valid && (state_q == S_IDLE);
        is_byte    = (req_func3[1:0] == 2'b00);
        is_half    = (req_func3[1:0] == 2'b01);
        is_word    = (req_func3[1:0] == 2'b10);
        if (req_we) func3_ok = (req_func3 == 3'b000) || (req_func3 == 3'b001) || (req_func3 == 3'b010);
        else        func3_ok = (req_func3 == 3'b000) || (req_func3 == 3'b001) || (req_func3 == 3'b010) ||
                               (req_func3 == 3'b100) || (req_func3 == 3'b101);
        misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
        req_err    = !func3_ok || misaligned || out_of_range;
        idx        = req_addr[IDX_W+1:2];
    end

    // Lane extraction and extension of the addressed word, little-endian.
    always_comb begin
        rd_word = mem[idx];
        case (req_addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (req_func3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'd0, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'd0, rd_half};
            3'b010:  load_data = rd_word;
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = req_wdata;
        if (is_byte) begin
            wr_be   = 4'b0001 << req_addr[1:0];
            wr_data = {4{req_wdata[7:0]}};
        end else if (is_half) begin
            wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{req_wdata[15:0]}};
        end else if (is_word) begin
            wr_be   = 4'b1111;
        end
        wr_en = accept && req_we && !req_err;
    end

    // Memory content is deliberately excluded from reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_be[b]) mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    err_d   = req_err;
                    rdata_d = (req_we || req_err) ? 32'd0 : load_data;
                    if (RD_LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(RD_LATENCY - 2);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perf_loads_q, perf_loads_d;
    logic [31:0] perf_stores_q, perf_stores_d;
    logic [31:0] perf_errs_q, perf_errs_d;

    always_comb begin
        perf_loads_d  = perf_loads_q;
        perf_stores_d = perf_stores_q;
        perf_errs_d   = perf_errs_q;
        if (accept) begin
            if (req_err) begin
                if (perf_errs_q != 32'hFFFF_FFFF) perf_errs_d = perf_errs_q + 32'd1;
            end else if (req_we) begin
                if (perf_stores_q != 32'hFFFF_FFFF) perf_stores_d = perf_stores_q + 32'd1;
            end else begin
                if (perf_loads_q != 32'hFFFF_FFFF) perf_loads_d = perf_loads_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_loads_q  <= 32'd0;
            perf_stores_q <= 32'd0;
            perf_errs_q   <= 32'd0;
        end else begin
            perf_loads_q  <= perf_loads_d;
            perf_stores_q <= perf_stores_d;
            perf_errs_q   <= perf_errs_d;
        end
    end

    assign perf_loads  = perf_loads_q;
    assign perf_stores = perf_stores_q;
    assign perf_errs   = perf_errs_q;
`endif

endmodule

// File: tb/tb_dmem_lsu_hs.sv
// Directed bench for dmem_lsu_hs: one instance with RD_LATENCY=1, one with RD_LATENCY=3.
// Perf counter checks are compiled in when DMEM_PERF_CNT_EN is defined.
module tb_dmem_lsu_hs;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [2:0]  req_func3 [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perf_loads  [2];
    logic [31:0] perf_stores [2];
    logic [31:0] perf_errs   [2];
`endif
    int exp_ld [2];
    int exp_st [2];
    int exp_er [2];

    int n_cmp;
    int n_bad;

    dmem_lsu_hs #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .RD_LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_func3(req_func3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
`ifdef DMEM_PERF_CNT_EN
        , .perf_loads(perf_loads[0]), .perf_stores(perf_stores[0]), .perf_errs(perf_errs[0])
`endif
    );

    dmem_lsu_hs #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .RD_LATENCY(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_func3(req_func3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
`ifdef DMEM_PERF_CNT_EN
        , .perf_loads(perf_loads[1]), .perf_stores(perf_stores[1]), .perf_errs(perf_errs[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          we;
        bit [2:0]    f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t tbl [$];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (lat%0d): got 0x%08h, expected 0x%08h", nm, lat_of(d), act, exp);
        end
    endtask

    task automatic add(input string nm, input bit we, input bit [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit exp_err);
        vec_t v;
        v.name = nm; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        tbl.push_back(v);
    endtask

    task automatic count_perf(input int d, input bit we, input bit err);
        if (err)     exp_er[d]++;
        else if (we) exp_st[d]++;
        else         exp_ld[d]++;
    endtask

    // Full request/response transaction with rsp_ready held high; called #1 after a rising edge.
    task automatic access(input int d, input string nm, input bit we, input bit [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input bit exp_err);
        int n;
        chk({nm, ".ready_before"}, d, 32'(req_ready[d]), 32'd1);
        req_we[d] = we; req_func3[d] = f3; req_addr[d] = addr; req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        chk({nm, ".ready_busy"}, d, 32'(req_ready[d]), 32'd0);
        n = 0;
        while (!rsp_valid[d] && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, ".latency"}, d, 32'(n), 32'(lat_of(d) - 1));
        chk({nm, ".rdata"}, d, rsp_rdata[d], exp_rdata);
        chk({nm, ".err"}, d, 32'(rsp_err[d]), 32'(exp_err));
        $display("lat%0d %-12s we=%0d f3=%03b addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d",
                 lat_of(d), nm, we, f3, addr, wdata, rsp_rdata[d], rsp_err[d]);
        count_perf(d, we, exp_err);
        @(posedge clk); #1;
        chk({nm, ".idle_after"}, d, {30'd0, req_ready[d], rsp_valid[d]}, 32'd2);
    endtask

    task automatic chk_perf(input string nm);
`ifdef DMEM_PERF_CNT_EN
        for (int d = 0; d < 2; d++) begin
            chk({nm, ".perf_loads"}, d, perf_loads[d], 32'(exp_ld[d]));
            chk({nm, ".perf_stores"}, d, perf_stores[d], 32'(exp_st[d]));
            chk({nm, ".perf_errs"}, d, perf_errs[d], 32'(exp_er[d]));
        end
`else
        $display("perf counters not built (%s)", nm);
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_func3[d] = 3'd0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b1;
            exp_ld[d] = 0; exp_st[d] = 0; exp_er[d] = 0;
        end

        add("SW0",     1, 3'b010, 32'd0,    32'h8000FF7F, 32'h0,        0);
        add("LB0",     0, 3'b000, 32'd0,    32'h0,        32'h0000007F, 0);
        add("LB1",     0, 3'b000, 32'd1,    32'h0,        32'hFFFFFFFF, 0);
        add("LBU1",    0, 3'b100, 32'd1,    32'h0,        32'h000000FF, 0);
        add("LH2",     0, 3'b001, 32'd2,    32'h0,        32'hFFFF8000, 0);
        add("LHU2",    0, 3'b101, 32'd2,    32'h0,        32'h00008000, 0);
        add("LW0",     0, 3'b010, 32'd0,    32'h0,        32'h8000FF7F, 0);
        add("LB3",     0, 3'b000, 32'd3,    32'h0,        32'hFFFFFF80, 0);
        add("LBU3",    0, 3'b100, 32'd3,    32'h0,        32'h00000080, 0);
        add("LH0",     0, 3'b001, 32'd0,    32'h0,        32'hFFFFFF7F, 0);
        add("LHU0",    0, 3'b101, 32'd0,    32'h0,        32'h0000FF7F, 0);
        add("SW4",     1, 3'b010, 32'd4,    32'h0,        32'h0,        0);
        add("SB5",     1, 3'b000, 32'd5,    32'h123456AB, 32'h0,        0);
        add("SH6",     1, 3'b001, 32'd6,    32'h0000BEEF, 32'h0,        0);
        add("LW4",     0, 3'b010, 32'd4,    32'h0,        32'hBEEFAB00, 0);
        add("LW2_mis", 0, 3'b010, 32'd2,    32'h0,        32'h0,        1);
        add("SW6_mis", 1, 3'b010, 32'd6,    32'hFFFFFFFF, 32'h0,        1);
        add("LW4_b",   0, 3'b010, 32'd4,    32'h0,        32'hBEEFAB00, 0);
        add("LD_f011", 0, 3'b011, 32'd0,    32'h0,        32'h0,        1);
        add("LW_oor",  0, 3'b010, 32'(4*DEPTH), 32'h0,    32'h0,        1);
        add("SW_oor",  1, 3'b010, 32'(4*DEPTH+4), 32'h11111111, 32'h0,  1);
        add("SB_oor",  1, 3'b000, 32'(4*DEPTH), 32'h22,   32'h0,        1);
        add("ST_f100", 1, 3'b100, 32'd0,    32'h33333333, 32'h0,        1);
        add("LH1_mis", 0, 3'b001, 32'd1,    32'h0,        32'h0,        1);
        add("SH3_mis", 1, 3'b001, 32'd3,    32'h44444444, 32'h0,        1);
        add("LW4_c",   0, 3'b010, 32'd4,    32'h0,        32'hBEEFAB00, 0);
        add("LW0_b",   0, 3'b010, 32'd0,    32'h0,        32'h8000FF7F, 0);

        #3;
        for (int d = 0; d < 2; d++) begin
            chk("reset.req_ready", d, 32'(req_ready[d]), 32'd1);
            chk("reset.rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
            chk("reset.rsp_rdata", d, rsp_rdata[d], 32'd0);
            chk("reset.rsp_err", d, 32'(rsp_err[d]), 32'd0);
        end
        chk_perf("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < tbl.size(); i++) begin
                access(d, tbl[i].name, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                       tbl[i].exp_rdata, tbl[i].exp_err);
            end
        end

        // Backpressure: response must hold while a competing request is refused.
        for (int d = 0; d < 2; d++) begin
            int n;
            rsp_ready[d] = 1'b0;
            req_we[d] = 1'b0; req_func3[d] = 3'b010; req_addr[d] = 32'd0; req_valid[d] = 1'b1;
            @(posedge clk); #1;
            req_valid[d] = 1'b0;
            n = 0;
            while (!rsp_valid[d] && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            chk("bp.latency", d, 32'(n), 32'(lat_of(d) - 1));
            count_perf(d, 1'b0, 1'b0);
            req_we[d] = 1'b1; req_wdata[d] = 32'h0; req_valid[d] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                chk("bp.rsp_valid", d, 32'(rsp_valid[d]), 32'd1);
                chk("bp.rsp_rdata", d, rsp_rdata[d], 32'h8000FF7F);
                chk("bp.req_ready", d, 32'(req_ready[d]), 32'd0);
            end
            $display("lat%0d backpressure held 4 cycles rdata=0x%08h", lat_of(d), rsp_rdata[d]);
            req_valid[d] = 1'b0;
            req_we[d] = 1'b0;
            rsp_ready[d] = 1'b1;
            @(posedge clk); #1;
            chk("bp.release", d, {30'd0, req_ready[d], rsp_valid[d]}, 32'd2);
            access(d, "LW0_after_bp", 0, 3'b010, 32'd0, 32'h0, 32'h8000FF7F, 0);
        end

        chk_perf("run");

        // Asynchronous reset while the latency-3 instance is in WAIT.
        access(1, "SW8", 1, 3'b010, 32'd8, 32'hCAFEF00D, 32'h0, 0);
        req_we[1] = 1'b0; req_func3[1] = 3'b010; req_addr[1] = 32'd8; req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        chk("rst.in_wait", 1, {30'd0, req_ready[1], rsp_valid[1]}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.rsp_valid", 1, 32'(rsp_valid[1]), 32'd0);
        chk("rst.req_ready", 1, 32'(req_ready[1]), 32'd1);
        chk("rst.rsp_err", 1, 32'(rsp_err[1]), 32'd0);
        for (int d = 0; d < 2; d++) begin
            exp_ld[d] = 0; exp_st[d] = 0; exp_er[d] = 0;
        end
        chk_perf("after_reset");
        $display("lat3 async reset during WAIT -> rsp_valid=%0d req_ready=%0d", rsp_valid[1], req_ready[1]);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        access(1, "LW8_post", 0, 3'b010, 32'd8, 32'h0, 32'hCAFEF00D, 0);
        access(0, "LW4_post", 0, 3'b010, 32'd4, 32'h0, 32'hBEEFAB00, 0);

        // Exact counter scenario: 3 loads, 2 stores, 1 misaligned access.
        access(0, "pc_SW", 1, 3'b010, 32'd12, 32'h01020304, 32'h0, 0);
        access(0, "pc_SB", 1, 3'b000, 32'd13, 32'h000000AA, 32'h0, 0);
        access(0, "pc_LW", 0, 3'b010, 32'd12, 32'h0, 32'h0102AA04, 0);
        access(0, "pc_LHU", 0, 3'b101, 32'd14, 32'h0, 32'h00000102, 0);
        access(0, "pc_LH_mis", 0, 3'b001, 32'd13, 32'h0, 32'h0, 1);
        chk_perf("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
